// File: rtl/ser_frame_tx_if.sv
// ser_frame_tx_if: valid/ready word handshake into the serial frame transmitter.
interface ser_frame_tx_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/ser_frame_tx.sv
// ser_frame_tx: double-buffered 8-bit serialiser (start, data, stop, idle gap); idle-high line.
// Define SER_FRAME_TX_PARITY_EN to insert an even parity bit before the stop bit.
module ser_frame_tx #(
    parameter int MSB_FIRST = 1,
    parameter int GAP_BITS  = 1
) (
    input  logic          clock_40,
    input  logic          reset,
    input  logic          enable,
    ser_frame_tx_if.slave bus,
    output logic          data_out,
    output logic          busy,
    output logic [7:0]    frame_count
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd4;
    localparam logic [2:0] GAP   = 3'd5;
`ifdef SER_FRAME_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [3:0] GAP_LAST = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;
    logic [2:0] state;
    logic [7:0] hold_reg;
    logic [7:0] shift_reg;
    logic       hold_full;
    logic [2:0] bit_cnt;
    logic [3:0] gap_cnt;
    logic       head;
    logic [7:0] rotated;
    logic       accept;
    logic       gap_done;
    logic       load;
    // Rotating instead of shifting leaves the word intact after 8 bits, so parity needs no extra copy.
    assign head     = (MSB_FIRST != 0) ? shift_reg[7] : shift_reg[0];
    assign rotated  = (MSB_FIRST != 0) ? {shift_reg[6:0], shift_reg[7]} : {shift_reg[0], shift_reg[7:1]};
    assign accept   = bus.data_valid && !hold_full;
    assign gap_done = (state == GAP && gap_cnt == GAP_LAST) || (state == STOP && GAP_BITS == 0);
    assign load     = hold_full && enable && (state == IDLE || gap_done);
    assign bus.data_ready = !hold_full;
    assign busy     = state != IDLE;
    always_ff @(posedge clock_40 or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hold_reg    <= '0;
            shift_reg   <= '0;
            hold_full   <= 1'b0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            data_out    <= 1'b1;
            frame_count <= '0;
        end else begin
            if (load) begin
                hold_full <= 1'b0;
                shift_reg <= hold_reg;
            end else if (accept) begin
                hold_full <= 1'b1;
                hold_reg  <= bus.data_in;
            end
            case (state)
                START: begin
                    state     <= DATA;
                    data_out  <= head;
                    shift_reg <= rotated;
                    bit_cnt   <= '0;
                end
                DATA: begin
                    if (bit_cnt == 3'd7) begin
`ifdef SER_FRAME_TX_PARITY_EN
                        state    <= PARITY;
                        data_out <= ^shift_reg;
`else
                        state    <= STOP;
                        data_out <= 1'b1;
`endif
                    end else begin
                        data_out  <= head;
                        shift_reg <= rotated;
                        bit_cnt   <= bit_cnt + 3'd1;
                    end
                end
`ifdef SER_FRAME_TX_PARITY_EN
                PARITY: begin
                    state    <= STOP;
                    data_out <= 1'b1;
                end
`endif
                STOP: begin
                    frame_count <= frame_count + 8'd1;
                    state       <= (GAP_BITS == 0) ? IDLE : GAP;
                    gap_cnt     <= '0;
                    data_out    <= 1'b1;
                end
                GAP: begin
                    state   <= gap_done ? IDLE : GAP;
                    gap_cnt <= gap_cnt + 4'd1;
                end
                default: begin
                    state    <= IDLE;
                    data_out <= 1'b1;
                end
            endcase
            // A waiting word starts on the same edge that ends the gap, so frames run back to back.
            if (load) begin
                state    <= START;
                data_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ser_frame_tx.sv
// tb_ser_frame_tx: random and directed frames decoded off the serial line and compared to expected bit patterns.
module tb_ser_frame_tx;
    localparam int MSB_FIRST = 1;
    localparam int GAP_BITS  = 1;
`ifdef SER_FRAME_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       data_out;
    logic       busy;
    logic [7:0] frame_count;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         mon_cnt = 0;
    int         start_cyc = 0;
    int         wraps = 0;
    int         model_fc = 0;
    logic [10:0] mon_bits = '0;
    logic [7:0]  prev_fc = '0;
    logic [7:0]  exp_q[$];
    logic [10:0] rx_q[$];
    int          rx_start_q[$];
    ser_frame_tx_if bus ();
    ser_frame_tx #(.MSB_FIRST(MSB_FIRST), .GAP_BITS(GAP_BITS)) dut (
        .clock_40(clk), .reset(rst_n), .enable(enable), .bus(bus),
        .data_out(data_out), .busy(busy), .frame_count(frame_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Expected line bits of one frame, first bit sent ends up most significant.
    function automatic logic [10:0] exp_frame(input logic [7:0] w);
        logic [10:0] v = '0;
        for (int i = 0; i < 8; i++) v = {v[9:0], (MSB_FIRST != 0) ? w[7-i] : w[i]};
`ifdef SER_FRAME_TX_PARITY_EN
        v = {v[9:0], ^w};
`endif
        v = {v[9:0], 1'b1};
        return v;
    endfunction
    always @(negedge clk) begin
        cyc++;
        if (frame_count == 8'd0 && prev_fc == 8'd255) wraps++;
        prev_fc = frame_count;
        if (!rst_n) mon_cnt = 0;
        else if (mon_cnt > 0 || data_out == 1'b0) begin
            if (mon_cnt == 0) begin
                start_cyc = cyc;
                mon_bits = '0;
            end
            mon_bits = {mon_bits[9:0], data_out};
            mon_cnt++;
            if (mon_cnt == FL) begin
                rx_q.push_back(mon_bits);
                rx_start_q.push_back(start_cyc);
                mon_cnt = 0;
            end
        end
    end
    task automatic send(input logic [7:0] w);
        int t = 0;
        @(negedge clk);
        while (!bus.data_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("send_ready", bus.data_ready, 1);
        bus.data_in = w;
        bus.data_valid = 1'b1;
        exp_q.push_back(w);
        @(negedge clk);
        bus.data_valid = 1'b0;
    endtask
    task automatic wait_idle();
        int t = 0;
        while (!(busy == 1'b0 && bus.data_ready == 1'b1) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("idle_timeout", busy, 0);
    endtask
    task automatic check_rx(input string tag);
        chk({tag, "_nframes"}, rx_q.size(), exp_q.size());
        model_fc += exp_q.size();
        while (rx_q.size() > 0 && exp_q.size() > 0) chk({tag, "_frame"}, rx_q.pop_front(), exp_frame(exp_q.pop_front()));
        rx_q.delete();
        exp_q.delete();
        rx_start_q.delete();
        chk({tag, "_frame_count"}, frame_count, model_fc % 256);
    endtask
    initial begin
        bus.data_in = '0;
        bus.data_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data_out", data_out, 1);
        chk("rst_ready", bus.data_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_count", frame_count, 0);
        #2 rst_n = 1'b1;
        send(8'hBB);
        chk("lat_ready_low", bus.data_ready, 0);
        chk("lat_no_start_yet", data_out, 1);
        chk("lat_busy_low", busy, 0);
        @(negedge clk);
        chk("lat_start_bit", data_out, 0);
        chk("lat_busy", busy, 1);
        chk("lat_fc_before", frame_count, 0);
        @(negedge clk);
        wait_idle();
        chk("bb_exact", rx_q.size() > 0 ? rx_q[0] : 11'h7FF, {1'b0, 8'hBB, `ifdef SER_FRAME_TX_PARITY_EN 1'b0, `endif 1'b1});
        check_rx("single");
        send(8'hBB);
        send(8'h55);
        chk("b2b_busy_at_accept", busy, 1);
        @(negedge clk);
        wait_idle();
        chk("b2b_nstart", rx_start_q.size(), 2);
        if (rx_start_q.size() >= 2) chk("b2b_spacing", rx_start_q[1] - rx_start_q[0], FL + GAP_BITS);
        check_rx("b2b");
        for (int i = 0; i < 20; i++) begin
            send(8'($urandom));
            repeat ($urandom_range(0, 2 * FL)) @(negedge clk);
        end
        @(negedge clk);
        wait_idle();
        check_rx("rand");
        send(8'hA5);
        send(8'h3C);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (FL + GAP_BITS + 4) @(negedge clk);
        chk("en_off_line", data_out, 1);
        chk("en_off_ready", bus.data_ready, 0);
        chk("en_off_busy", busy, 0);
        chk("en_off_nframes", rx_q.size(), 1);
        enable = 1'b1;
        @(negedge clk);
        chk("en_on_start", data_out, 0);
        @(negedge clk);
        wait_idle();
        check_rx("enable");
        send(8'hF0);
        repeat (3) @(negedge clk);
        chk("ar_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_data_out", data_out, 1);
        chk("ar_ready", bus.data_ready, 1);
        chk("ar_busy", busy, 0);
        chk("ar_frame_count", frame_count, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        exp_q.delete();
        rx_q.delete();
        rx_start_q.delete();
        model_fc = 0;
        wraps = 0;
        for (int i = 0; i < 257; i++) send(8'($urandom));
        @(negedge clk);
        wait_idle();
        check_rx("wrap");
        chk("wrap_once", wraps, 1);
        chk("wrap_fc_one", frame_count, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
